// File: rtl/stack_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg
// Shared types and helpers for the two-requester LIFO arbiter (stack_arb) and
// its storage array (stack_mem).
//   stack_op_e : per-requester opcode encoding (push / pop)
//   NREQ       : number of requesters served by the arbiter
//   cnt_width  : bit width needed to hold an occupancy of 0..depth
// -----------------------------------------------------------------------------
package stack_pkg;

    typedef enum logic {
        OP_PUSH = 1'b0,
        OP_POP  = 1'b1
    } stack_op_e;

    localparam int NREQ = 2;

    // Occupancy runs 0..depth inclusive, so one more code than entries.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stack_mem.sv
// -----------------------------------------------------------------------------
// stack_mem
// Storage array for the shared LIFO. Contents are deliberately not reset; the
// controller never returns an entry at or above the current occupancy.
// Ports:
//   clk    in   clock, rising edge
//   we     in   write enable
//   waddr  in   write index
//   wdat   in   write data
//   raddr  in   read index
//   rdat   out  read data, combinational from raddr
// -----------------------------------------------------------------------------
module stack_mem #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdat,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdat
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Synchronous write port; no reset on the array.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdat;
        end
    end

    assign rdat = mem_r[raddr];

endmodule

// File: rtl/stack_arb.sv
// -----------------------------------------------------------------------------
// stack_arb
// Round-robin arbiter and controller for a LIFO shared by two requesters.
// One push or pop is accepted per cycle; overflow and underflow are rejected
// with an error response. Responses appear the cycle after the accept.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous, active-high reset
//   req_valid  in   [NREQ]        request present per requester
//   req_op     in   [NREQ]        opcode per requester (0 push, 1 pop)
//   req_dat    in   [NREQ][WIDTH] push data per requester
//   req_ready  out  [NREQ]        grant (one-hot or zero)
//   rsp_valid  out  [NREQ]        one-cycle response pulse per requester
//   rsp_dat    out  [WIDTH]       popped data, zero for pushes and errors
//   rsp_err    out                overflow / underflow indication
//   count      out                current occupancy 0..DEPTH
//   full       out                count == DEPTH
//   empty      out                count == 0
// -----------------------------------------------------------------------------
module stack_arb
    import stack_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NREQ-1:0]                   req_valid,
    input  logic [NREQ-1:0]                   req_op,
    input  logic [NREQ-1:0][WIDTH-1:0]        req_dat,
    output logic [NREQ-1:0]                   req_ready,
    output logic [NREQ-1:0]                   rsp_valid,
    output logic [WIDTH-1:0]                  rsp_dat,
    output logic                              rsp_err,
    output logic [$clog2(DEPTH+1)-1:0]        count,
    output logic                              full,
    output logic                              empty
);

    localparam int CW = cnt_width(DEPTH);
    localparam int AW = $clog2(DEPTH);

    // Arbitration / decode
    logic [NREQ-1:0]  gnt_s;
    logic             acc_s;
    logic             acc_idx_s;
    stack_op_e        acc_op_s;
    logic [WIDTH-1:0] acc_dat_s;
    logic             push_ok_s;
    logic             pop_ok_s;
    logic             err_s;
    logic             full_s;
    logic             empty_s;

    // State
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;
    logic             pri_r;
    logic             pri_nxt_s;

    // Response registers
    logic [NREQ-1:0]  rsp_valid_r;
    logic [WIDTH-1:0] rsp_dat_r;
    logic             rsp_err_r;

    // Storage interface
    logic [AW-1:0]    waddr_s;
    logic [AW-1:0]    raddr_s;
    logic [WIDTH-1:0] rdat_s;

    assign full_s  = (count_r == CW'(DEPTH));
    assign empty_s = (count_r == {CW{1'b0}});

    // Write lands at index count; the top of stack sits at count-1. The
    // subtraction is done at address width so a full stack wraps to DEPTH-1
    // correctly when DEPTH is a power of two.
    assign waddr_s = count_r[AW-1:0];
    assign raddr_s = count_r[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};

    // Round-robin grant: a lone requester always wins, ties go to pri_r.
    always_comb begin
        gnt_s = {NREQ{1'b0}};
        if (rst) begin
            gnt_s = {NREQ{1'b0}};
        end else begin
            case (req_valid)
                2'b01:   gnt_s = 2'b01;
                2'b10:   gnt_s = 2'b10;
                2'b11:   gnt_s = pri_r ? 2'b10 : 2'b01;
                default: gnt_s = 2'b00;
            endcase
        end
    end

    // Decode the accepted transaction into push / pop / error.
    always_comb begin
        acc_s     = |gnt_s;
        acc_idx_s = gnt_s[1];
        acc_op_s  = stack_op_e'(req_op[acc_idx_s]);
        acc_dat_s = req_dat[acc_idx_s];
        push_ok_s = 1'b0;
        pop_ok_s  = 1'b0;
        err_s     = 1'b0;
        if (acc_s) begin
            case (acc_op_s)
                OP_PUSH: begin
                    if (full_s) begin
                        err_s = 1'b1;
                    end else begin
                        push_ok_s = 1'b1;
                    end
                end
                OP_POP: begin
                    if (empty_s) begin
                        err_s = 1'b1;
                    end else begin
                        pop_ok_s = 1'b1;
                    end
                end
                default: err_s = 1'b1;
            endcase
        end else begin
            push_ok_s = 1'b0;
            pop_ok_s  = 1'b0;
            err_s     = 1'b0;
        end
    end

    // Next occupancy and priority; priority rotates away from the winner
    // on every accept, including rejected (error) transactions.
    always_comb begin
        count_nxt_s = count_r;
        pri_nxt_s   = pri_r;
        if (push_ok_s) begin
            count_nxt_s = count_r + {{(CW-1){1'b0}}, 1'b1};
        end else if (pop_ok_s) begin
            count_nxt_s = count_r - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_nxt_s = count_r;
        end
        if (acc_s) begin
            pri_nxt_s = ~acc_idx_s;
        end else begin
            pri_nxt_s = pri_r;
        end
    end

    // State and response registers; reset drops any pending response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r     <= {CW{1'b0}};
            pri_r       <= 1'b0;
            rsp_valid_r <= {NREQ{1'b0}};
            rsp_dat_r   <= {WIDTH{1'b0}};
            rsp_err_r   <= 1'b0;
        end else begin
            count_r     <= count_nxt_s;
            pri_r       <= pri_nxt_s;
            rsp_valid_r <= gnt_s;
            rsp_dat_r   <= pop_ok_s ? rdat_s : {WIDTH{1'b0}};
            rsp_err_r   <= err_s;
        end
    end

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok_s),
        .waddr (waddr_s),
        .wdat  (acc_dat_s),
        .raddr (raddr_s),
        .rdat  (rdat_s)
    );

    assign req_ready = gnt_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_dat   = rsp_dat_r;
    assign rsp_err   = rsp_err_r;
    assign count     = count_r;
    assign full      = full_s;
    assign empty     = empty_s;

endmodule

// File: tb/tb_stack_arb.sv
module tb_stack_arb;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic                   clk;
    logic                   rst;
    logic [1:0]             req_valid;
    logic [1:0]             req_op;
    logic [1:0][WIDTH-1:0]  req_dat;
    logic [1:0]             req_ready;
    logic [1:0]             rsp_valid;
    logic [WIDTH-1:0]       rsp_dat;
    logic                   rsp_err;
    logic [CW-1:0]          count;
    logic                   full;
    logic                   empty;

    typedef struct {
        int               idx;
        logic [WIDTH-1:0] dat;
        logic             err;
    } exp_t;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;

    stack_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_dat   (req_dat),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: every response pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid !== 2'b00) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", {30'd0, rsp_valid}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_valid", {30'd0, rsp_valid}, (e.idx == 1) ? 32'd2 : 32'd1);
                check("rsp_dat", {28'd0, rsp_dat}, {28'd0, e.dat});
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the accept.
    task automatic issue(input int r, input logic op, input logic [WIDTH-1:0] d,
                         input logic [WIDTH-1:0] edat, input logic eerr, input int ecnt);
        int   n;
        exp_t e;
        req_valid[r] = 1'b1;
        req_op[r]    = op;
        req_dat[r]   = d;
        n = 0;
        #1;
        while (!req_ready[r] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!req_ready[r]) begin
            check("grant_timeout", 32'd0, 32'd1);
            req_valid[r] = 1'b0;
        end else begin
            e.idx = r;
            e.dat = edat;
            e.err = eerr;
            exp_q.push_back(e);
            @(posedge clk);
            @(negedge clk);
            req_valid[r] = 1'b0;
            check("rsp_latency", {31'd0, rsp_valid[r]}, 32'd1);
            check("count", {29'd0, count}, ecnt);
        end
    endtask

    // Both requesters push continuously; grants must alternate from 'first'.
    task automatic contend(input int n, input logic [1:0] first,
                           input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1, input int cnt0);
        logic [1:0] g;
        exp_t       e;
        g = first;
        req_valid  = 2'b11;
        req_op     = 2'b00;
        req_dat[0] = d0;
        req_dat[1] = d1;
        for (int i = 0; i < n; i++) begin
            #1;
            check("grant", {30'd0, req_ready}, {30'd0, g});
            e.idx = g[1] ? 1 : 0;
            e.dat = '0;
            e.err = 1'b0;
            exp_q.push_back(e);
            @(posedge clk);
            @(negedge clk);
            check("count", {29'd0, count}, cnt0 + i + 1);
            g = ~g;
        end
        req_valid = 2'b00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 2'b11;
        #1;
        check("rst_ready", {30'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("rst_rsp_dat", {28'd0, rsp_dat}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        req_valid = 2'b00;
        rst       = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        req_valid   = 2'b00;
        req_op      = 2'b00;
        req_dat     = '0;
        repeat (2) @(posedge clk);
        do_reset();

        // 1: single requester push/pop
        issue(0, 1'b0, 4'h3, 4'h0, 1'b0, 1);
        issue(0, 1'b0, 4'h5, 4'h0, 1'b0, 2);
        issue(0, 1'b1, 4'h0, 4'h5, 1'b0, 1);
        issue(0, 1'b1, 4'h0, 4'h3, 1'b0, 0);
        check("empty_after_pops", {31'd0, empty}, 32'd1);

        // 2: contention from reset, r0 first; stack becomes A,B,A,B
        do_reset();
        contend(4, 2'b01, 4'hA, 4'hB, 0);
        check("full_after_fill", {31'd0, full}, 32'd1);

        // 3: overflow, then drain returns B,A,B,A (never C)
        issue(1, 1'b0, 4'hC, 4'h0, 1'b1, 4);
        issue(0, 1'b1, 4'h0, 4'hB, 1'b0, 3);
        issue(0, 1'b1, 4'h0, 4'hA, 1'b0, 2);
        issue(1, 1'b1, 4'h0, 4'hB, 1'b0, 1);
        issue(0, 1'b1, 4'h0, 4'hA, 1'b0, 0);

        // 4: underflow by r0, then r1 must win the next tie
        issue(0, 1'b1, 4'h0, 4'h0, 1'b1, 0);
        check("empty_after_underflow", {31'd0, empty}, 32'd1);
        contend(2, 2'b10, 4'h1, 4'h2, 0);
        issue(0, 1'b1, 4'h0, 4'h1, 1'b0, 1);
        issue(1, 1'b1, 4'h0, 4'h2, 1'b0, 0);

        // 5: back-to-back push by r0, pop by r1
        issue(0, 1'b0, 4'h7, 4'h0, 1'b0, 1);
        issue(1, 1'b1, 4'h0, 4'h7, 1'b0, 0);

        // 6: reset right after an accepted pop drops the response
        issue(0, 1'b0, 4'h9, 4'h0, 1'b0, 1);
        issue(1, 1'b0, 4'h6, 4'h0, 1'b0, 2);
        req_valid[0] = 1'b1;
        req_op[0]    = 1'b1;
        #1;
        check("pop_grant", {30'd0, req_ready}, 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("midrst_count", {29'd0, count}, 32'd0);
        check("midrst_ready", {30'd0, req_ready}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        req_valid = 2'b00;
        rst       = 1'b0;
        contend(2, 2'b01, 4'h3, 4'h4, 0);
        issue(1, 1'b1, 4'h0, 4'h4, 1'b0, 1);
        issue(0, 1'b1, 4'h0, 4'h3, 1'b0, 0);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
